// File: rtl/inv_shift_rows_pipe.sv
// Two-stage AES-128 inverse-round slice: InvShiftRows -> AddRoundKey -> optional InvMixColumns.
// Stage A registers the row-shifted state; stage B registers the keyed, optionally mixed result.
module inv_shift_rows_pipe (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  input  logic         mix_en,
  input  logic [3:0]   tag_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic [3:0]   tag_out,
  output logic         busy
);

  // Handshake: a beat moves on a rising edge when valid && ready on that side;
  // a producer holds valid and its payload steady until that edge.

  logic         a_valid;
  logic [127:0] a_state;
  logic [127:0] a_key;
  logic         a_mix;
  logic [3:0]   a_tag;
  logic         b_valid;
  logic         b_take;
  logic         a_take;
  logic [127:0] t_state;
  logic [127:0] mixed_state;
  logic [127:0] b_next;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] s  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      s[r]  = col[31-8*r -: 8];
      x2    = xtime(s[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ s[r];
      mb[r] = x8 ^ x2 ^ s[r];
      md[r] = x8 ^ x4 ^ s[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Row r rotates right by r columns: out[r][c] = in[r][(c-r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] st);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = st[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

  assign b_take    = !b_valid || out_ready;
  assign a_take    = !a_valid || b_take;
  assign in_ready  = !rst && a_take;
  assign out_valid = b_valid;
  assign busy      = a_valid || b_valid;

  always_comb begin
    t_state     = a_state ^ a_key;
    mixed_state = '0;
    for (int c = 0; c < 4; c++) begin
      mixed_state[127-32*c -: 32] = inv_mix_col(t_state[127-32*c -: 32]);
    end
    b_next = a_mix ? mixed_state : t_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_state <= '0;
      a_key   <= '0;
      a_mix   <= 1'b0;
      a_tag   <= '0;
    end else if (a_take) begin
      a_valid <= in_valid && in_ready;
      a_state <= inv_shift_rows(data_in);
      a_key   <= key_in;
      a_mix   <= mix_en;
      a_tag   <= tag_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid  <= 1'b0;
      data_out <= '0;
      tag_out  <= '0;
    end else if (b_take) begin
      b_valid  <= a_valid;
      data_out <= b_next;
      tag_out  <= a_tag;
    end
  end

endmodule

// File: doc/inv_shift_rows_pipe.md
# inv_shift_rows_pipe

Two-stage, valid/ready pipelined AES-128 inverse-round datapath slice for the decryption path. It applies InvShiftRows, then AddRoundKey, then an optional InvMixColumns to a 128-bit state. It is the decrypt-side counterpart of the encrypt-side row-shift stage and uses the same column-major state layout. It sits between the decrypt round controller (upstream) and the InvSubBytes stage (downstream), and supports full backpressure.

## Interface
- No parameters; the state width is fixed at 128 bits.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream has a beat
- in_ready  output  1  block accepts a beat this cycle
- data_in  input  128  state; byte i = data_in[127-8i -: 8], row = i%4, col = i/4
- key_in  input  128  round key, same byte layout as data_in
- mix_en  input  1  1 = apply InvMixColumns; 0 = skip (final decrypt round)
- tag_in  input  4  sideband ID, carried through unchanged
- out_valid  output  1  data_out, tag_out valid
- out_ready  input  1  downstream accepts
- data_out  output  128  result state
- tag_out  output  4  tag of the beat on data_out
- busy  output  1  at least one stage occupied

## Operation
- A beat transfers on a rising edge when in_valid && in_ready. The output transfers when out_valid && out_ready.
- **Stage A** registers InvShiftRows(data_in), key_in, mix_en and tag_in, and sets a_valid.
  - InvShiftRows: out[r][c] = in[r][(c-r) mod 4].
  - In byte indices, output bytes 0..15 take input bytes 0,13,10,7, 4,1,14,11, 8,5,2,15, 12,9,6,3.
- **Stage B** computes t = A_state XOR A_key, then data_out = mix_en ? InvMixColumns(t) : t. It registers the result with the tag and sets b_valid.
  - InvMixColumns works per column over GF(2^8), reduction polynomial 0x11B.
  - Per column: s0' = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3, then rotate the coefficients for rows 1..3.
  - Implement with xtime chains, not lookup tables.
- **Stall rules:**
  - b_take = !b_valid || out_ready.
  - a_take = !a_valid || b_take.
  - in_ready = !rst && a_take. This is a combinational path from out_ready to in_ready, and that path is permitted.
- **Stage B update on each edge:**
  - If b_take: B loads A's contents and b_valid <= a_valid.
  - Otherwise B holds its contents.
- **Stage A update on each edge:**
  - If a_take: A loads the input beat and a_valid <= (in_valid && in_ready).
  - Otherwise A holds its contents.
- Simultaneous input accept, A→B move and output drain are all legal in one cycle. This sustains 1 beat/cycle.
- Data and tag registers of a stage update only when that stage loads. Their contents are don't-care while the stage's valid bit is 0, except after reset (see below).
- busy = a_valid || b_valid.
- No ordering changes: beats exit in acceptance order.

## Timing
- **Reset (asynchronous assert):**
  - a_valid = b_valid = 0; out_valid = 0; busy = 0.
  - data_out = 0; tag_out = 0; stage A registers = 0.
  - in_ready = 0 while rst is high; inputs are ignored.
  - in_ready = 1 in the first cycle after rst deasserts.
- **Reset mid-operation:** in-flight beats are dropped and no partial output appears.
- **Latency:** a beat accepted at edge k appears on data_out with out_valid = 1 right after edge k+1 (2-register latency) when there is no stall.
- **out_valid stability:**
  - Once out_valid = 1 with out_ready = 0, data_out and tag_out hold stable until the transfer.
  - out_valid must not drop without a transfer.
- **Full condition:** a_valid && b_valid && !out_ready gives in_ready = 0. Capacity is 2 beats.
- **Drain from full:** one out_ready cycle both frees B and lets A move into B. in_ready is 1 in that same cycle.
- **Empty:** out_valid = 0. An input arriving while empty needs 2 edges to reach the output; there is no bypass.

## Test plan
- **InvShiftRows only:** data_in = 00 01 02 … 0f (byte 0 first), key_in = 0, mix_en = 0 → data_out = 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03, two edges after accept.
- **InvMixColumns:** data_in = {4{32'h8e4da1bc}}, key_in = 0, mix_en = 1 → data_out = {4{32'hdb135345}}. Repeat with data_in = 0 and key_in = {4{32'h8e4da1bc}}; the required result is the same, which proves AddRoundKey precedes the mix.
- **Backpressure:** stream tags 1..6 with in_valid held high and out_ready = 0 for 4 cycles, then 1.
  - in_ready falls after 2 accepts.
  - Tags exit as 1..6 in order with no loss or duplication.
  - data_out holds stable while stalled.
- **Full throughput:** 16 back-to-back beats with out_ready = 1 → in_ready constantly 1, 16 consecutive out_valid cycles, first at accept+2 edges.
- **Reset mid-flight:** assert rst with 2 beats buffered.
  - Outputs go to 0 asynchronously, before the next clock edge.
  - busy = 0.
  - After release, no stale beat appears; a new beat (tag 9) exits alone with correct data.
- **Random scoreboard:** 10k beats with random mix_en, key, in_valid and out_ready, checked against a reference model of InvShiftRows → XOR key → optional InvMixColumns.
